// File: rtl/kamacore_pkg.sv
// Shared types and constants for the kamacore memory stage.
package kamacore_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

  // Access size from funct3; unlisted encodings behave as a full word.
  function automatic mem_size_t decode_size(input logic [2:0] f3, input logic is_store);
    mem_size_t sz;
    sz = SZ_W;
    if (is_store) begin
      case (f3)
        F3_SB:   sz = SZ_B;
        F3_SH:   sz = SZ_H;
        F3_SW:   sz = SZ_W;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_B;
        F3_LH, F3_LHU: sz = SZ_H;
        F3_LW:         sz = SZ_W;
        default:       sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/kamacore_stage_mem_if.sv
// Data-memory request/response bus: valid/ready request, valid-only response.
interface kamacore_stage_mem_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic              dmem_req_we;
  logic [3:0]        dmem_req_be;
  logic [31:0]       dmem_req_wdata;
  logic              dmem_rsp_valid;
  logic [31:0]       dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

endinterface

// File: rtl/kamacore_lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extract/extend,
// and misalignment detection (only when KAMACORE_MEM_MISALIGN_TRAP_EN is defined).
module kamacore_lsu_align
  import kamacore_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  mem_size_t   size;
  logic        zext;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfword lane uses addr[1] only, so an unchecked odd address rounds down.
  always_comb begin
    size      = decode_size(funct3, is_store);
    zext      = !is_store && (funct3 == F3_LBU || funct3 == F3_LHU);
    byte_lane = load_word[{addr_lo, 3'b000} +: 8];
    half_lane = load_word[{addr_lo[1], 4'b0000} +: 16];
    be        = 4'hF;
    wdata     = store_data;
    load_data = load_word;
    misalign  = 1'b0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = zext ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      SZ_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = zext ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
        misalign  = addr_lo[0];
`endif
      end
      default: begin
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
        misalign  = |addr_lo;
`endif
      end
    endcase
  end

endmodule

// File: rtl/kamacore_stage_mem.sv
// Memory-access stage: issues data-memory requests, stalls while pending,
// and registers the MEM/WB bundle. Misaligned-access trapping is built in
// when KAMACORE_MEM_MISALIGN_TRAP_EN is defined; otherwise misalign stays 0.
module kamacore_stage_mem
  import kamacore_pkg::*;
#(
  parameter int unsigned XLEN   = CPU_WIDTH,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [31:0]           ex_instruction,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  output logic                  stall,
  kamacore_stage_mem_if.master  dmem,
  output logic                  wb_valid,
  output logic [31:0]           wb_instruction,
  output logic [XLEN-1:0]       wb_result,
  output logic                  wb_reg_write,
  output logic [4:0]            fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  misalign
);

  mem_state_t  state;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_ld, is_st, mem_op, trap, issue, load_done;
  logic        mis_raw, mis_q;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;

  assign funct3 = ex_instruction[14:12];
  assign rd     = ex_instruction[11:7];
  assign is_ld  = ex_valid & ex_mem_read;
  assign is_st  = ex_valid & ex_mem_write;
  assign mem_op = is_ld | is_st;
  assign trap   = mem_op & mis_raw;
  assign issue  = mem_op & ~trap;

  kamacore_lsu_align u_align (
    .funct3     (funct3),
    .is_store   (ex_mem_write),
    .addr_lo    (ex_alu_result[1:0]),
    .store_data (ex_store_data[31:0]),
    .load_word  (dmem.dmem_rsp_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data),
    .misalign   (mis_raw)
  );

  // Request fields come straight from ex_*, which upstream holds during stall.
  assign dmem.dmem_req_addr  = {ex_alu_result[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_req_we    = is_st;
  assign dmem.dmem_req_be    = be;
  assign dmem.dmem_req_wdata = wdata;

  assign fwd_rd    = (rst && ex_valid && ex_reg_write && !ex_mem_read) ? rd : '0;
  assign fwd_data  = ex_alu_result;
  assign misalign  = mis_q;
  assign load_done = (state == WAIT) && dmem.dmem_rsp_valid;

  // Request valid and stall per state; both forced low while in reset.
  always_comb begin
    stall               = 1'b0;
    dmem.dmem_req_valid = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          dmem.dmem_req_valid = issue;
          stall               = issue & ~(is_st & dmem.dmem_req_ready);
        end
        REQ: begin
          dmem.dmem_req_valid = 1'b1;
          stall               = ~(is_st & dmem.dmem_req_ready);
        end
        WAIT: stall = ~dmem.dmem_rsp_valid;
        default: ;
      endcase
    end
  end

  // Access FSM and MEM/WB register; stalled cycles push a bubble into WB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      wb_valid       <= 1'b0;
      wb_instruction <= '0;
      wb_result      <= '0;
      wb_reg_write   <= 1'b0;
      mis_q          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (issue) state <= dmem.dmem_req_ready ? (is_ld ? WAIT : IDLE) : REQ;
        REQ:  if (dmem.dmem_req_ready) state <= is_ld ? WAIT : IDLE;
        WAIT: if (dmem.dmem_rsp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (!stall) begin
        wb_valid       <= ex_valid;
        wb_instruction <= ex_instruction;
        wb_result      <= load_done ? load_data : ex_alu_result;
        wb_reg_write   <= ex_valid & ex_reg_write & (rd != 5'd0) & ~trap;
        mis_q          <= trap;
      end else begin
        wb_valid       <= 1'b0;
        wb_reg_write   <= 1'b0;
        mis_q          <= 1'b0;
      end
    end
  end

endmodule
